// File: rtl/mem_stream_loader.sv
// Streams words into / out of the three memory regions in region order, hiding the one-cycle read latency.
// Optional LOADER_CHECKSUM_EN builds a running XOR of every transferred word on the checksum port.
module mem_stream_loader #(
   parameter int WIDTH                = 32,
   parameter int SINGLE_MEM_DEPTH     = 14,
   parameter int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_load,
   input  logic                            start_unload,
   output logic                            busy,
   output logic                            done,
   input  logic                            s_valid,
   input  logic [WIDTH-1:0]                s_data,
   output logic                            s_ready,
   output logic                            m_valid,
   output logic [WIDTH-1:0]                m_data,
   input  logic                            m_ready,
   output logic                            mem_0_wr_en,
   output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_wr_addr,
   output logic [WIDTH-1:0]                mem_0_din,
   output logic                            mem_1_wr_en,
   output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_wr_addr,
   output logic [WIDTH-1:0]                mem_1_din,
   output logic                            mem_2_wr_en,
   output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_2_wr_addr,
   output logic [WIDTH-1:0]                mem_2_din,
   output logic                            mem_0_rd_en,
   output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_rd_addr,
   output logic                            mem_1_rd_en,
   output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_rd_addr,
   output logic                            mem_2_rd_en,
   output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_2_rd_addr,
   input  logic [WIDTH-1:0]                mem_dout,
   output logic [WIDTH-1:0]                checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, DRAIN} state_t;

   localparam logic [SINGLE_MEM_DEPTH_LOG-1:0] LAST_ADDR = SINGLE_MEM_DEPTH_LOG'(SINGLE_MEM_DEPTH - 1);

   state_t                          state;
   logic [1:0]                      region;
   logic [SINGLE_MEM_DEPTH_LOG-1:0] addr;
   logic                            inflight;
   logic [WIDTH-1:0]                fifo_mem [2];
   logic                            fifo_wr_ptr;
   logic                            fifo_rd_ptr;
   logic [1:0]                      fifo_count;
   logic                            done_q;

   logic       s_fire;
   logic       m_fire;
   logic       rd_issue;
   logic       step;
   logic       last_word;
   logic [2:0] occupancy;
   logic [1:0] fifo_count_next;
   logic [2:0] region_sel;
   logic [2:0] wr_sel;
   logic [2:0] rd_sel;

   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign s_ready   = (state == LOAD);
   assign m_valid   = (fifo_count != 2'd0);
   assign m_data    = m_valid ? fifo_mem[fifo_rd_ptr] : '0;
   assign s_fire    = s_ready & s_valid;
   assign m_fire    = m_valid & m_ready;
   assign last_word = (region == 2'd2) && (addr == LAST_ADDR);

   // A read may issue only if its word is guaranteed a FIFO slot when it lands next cycle.
   assign occupancy       = 3'(fifo_count) + 3'(inflight) - 3'(m_fire);
   assign rd_issue        = (state == UNLOAD) && (occupancy < 3'd2);
   assign step            = s_fire | rd_issue;
   assign fifo_count_next = fifo_count + 2'(inflight) - 2'(m_fire);

   always_comb begin
      case (region)
         2'd0:    region_sel = 3'b001;
         2'd1:    region_sel = 3'b010;
         2'd2:    region_sel = 3'b100;
         default: region_sel = 3'b000;
      endcase
   end

   assign wr_sel = s_fire   ? region_sel : 3'b000;
   assign rd_sel = rd_issue ? region_sel : 3'b000;

   assign mem_0_wr_en   = wr_sel[0];
   assign mem_0_wr_addr = wr_sel[0] ? addr : '0;
   assign mem_0_din     = wr_sel[0] ? s_data : '0;
   assign mem_1_wr_en   = wr_sel[1];
   assign mem_1_wr_addr = wr_sel[1] ? addr : '0;
   assign mem_1_din     = wr_sel[1] ? s_data : '0;
   assign mem_2_wr_en   = wr_sel[2];
   assign mem_2_wr_addr = wr_sel[2] ? addr : '0;
   assign mem_2_din     = wr_sel[2] ? s_data : '0;
   assign mem_0_rd_en   = rd_sel[0];
   assign mem_0_rd_addr = rd_sel[0] ? addr : '0;
   assign mem_1_rd_en   = rd_sel[1];
   assign mem_1_rd_addr = rd_sel[1] ? addr : '0;
   assign mem_2_rd_en   = rd_sel[2];
   assign mem_2_rd_addr = rd_sel[2] ? addr : '0;

   // The word fetched last cycle is always pushed; DRAIN waits until nothing is pending or buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         region      <= 2'd0;
         addr        <= '0;
         inflight    <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         fifo_wr_ptr <= 1'b0;
         fifo_rd_ptr <= 1'b0;
         fifo_count  <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight   <= rd_issue;
         fifo_count <= fifo_count_next;
         if (inflight) begin
            fifo_mem[fifo_wr_ptr] <= mem_dout;
            fifo_wr_ptr           <= ~fifo_wr_ptr;
         end
         if (m_fire) begin
            fifo_rd_ptr <= ~fifo_rd_ptr;
         end
         if (step) begin
            if (last_word) begin
               region <= 2'd0;
               addr   <= '0;
            end else if (addr == LAST_ADDR) begin
               region <= region + 2'd1;
               addr   <= '0;
            end else begin
               addr <= addr + SINGLE_MEM_DEPTH_LOG'(1);
            end
         end
         case (state)
            IDLE: begin
               if (start_load) begin
                  state  <= LOAD;
                  region <= 2'd0;
                  addr   <= '0;
               end else if (start_unload) begin
                  state  <= UNLOAD;
                  region <= 2'd0;
                  addr   <= '0;
               end
            end
            LOAD: begin
               if (s_fire && last_word) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            UNLOAD: begin
               if (rd_issue && last_word) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!inflight && (fifo_count_next == 2'd0)) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [WIDTH-1:0] checksum_q;

   // Cleared when a transfer starts; afterwards folds in each accepted word on either stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum_q <= '0;
      end else if ((state == IDLE) && (start_load || start_unload)) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_q ^ (s_fire ? s_data : '0) ^ (m_fire ? m_data : '0);
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_stream_loader.sv
// Self-checking bench for mem_stream_loader: table of transfer scenarios, a reset-abort sequence
// and randomized rounds, scored against a flat word-array model of the three regions.
`timescale 1ns/1ps
module tb_mem_stream_loader;

   localparam int WIDTH = 32;
   localparam int DEPTH = 14;
   localparam int TOTAL = 3 * DEPTH;
   localparam int AW    = $clog2(DEPTH);

   typedef struct {
      bit is_load;
      int pattern;
      int stall;
      int data_mode;
      bit both_start;
      bit mid_start;
      int exp_done;
      int exp_first_valid;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_load;
   logic             start_unload;
   logic             busy;
   logic             done;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_ready;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;
   logic             mem_0_wr_en, mem_1_wr_en, mem_2_wr_en;
   logic [AW-1:0]    mem_0_wr_addr, mem_1_wr_addr, mem_2_wr_addr;
   logic [WIDTH-1:0] mem_0_din, mem_1_din, mem_2_din;
   logic             mem_0_rd_en, mem_1_rd_en, mem_2_rd_en;
   logic [AW-1:0]    mem_0_rd_addr, mem_1_rd_addr, mem_2_rd_addr;
   logic [WIDTH-1:0] mem_dout;
   logic [WIDTH-1:0] checksum;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0] bus_mem   [3][16];
   int               wr_cnt    [3][16];
   logic [WIDTH-1:0] ref_words [TOTAL];
   vec_t             vectors   [8];

   logic             wr_en_a   [3];
   logic [AW-1:0]    wr_addr_a [3];
   logic [WIDTH-1:0] din_a     [3];
   logic             rd_en_a   [3];
   logic [AW-1:0]    rd_addr_a [3];

   assign wr_en_a[0] = mem_0_wr_en;     assign wr_en_a[1] = mem_1_wr_en;     assign wr_en_a[2] = mem_2_wr_en;
   assign wr_addr_a[0] = mem_0_wr_addr; assign wr_addr_a[1] = mem_1_wr_addr; assign wr_addr_a[2] = mem_2_wr_addr;
   assign din_a[0] = mem_0_din;         assign din_a[1] = mem_1_din;         assign din_a[2] = mem_2_din;
   assign rd_en_a[0] = mem_0_rd_en;     assign rd_en_a[1] = mem_1_rd_en;     assign rd_en_a[2] = mem_2_rd_en;
   assign rd_addr_a[0] = mem_0_rd_addr; assign rd_addr_a[1] = mem_1_rd_addr; assign rd_addr_a[2] = mem_2_rd_addr;

   mem_stream_loader #(
      .WIDTH(WIDTH),
      .SINGLE_MEM_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .start_load(start_load), .start_unload(start_unload),
      .busy(busy), .done(done),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .mem_0_wr_en(mem_0_wr_en), .mem_0_wr_addr(mem_0_wr_addr), .mem_0_din(mem_0_din),
      .mem_1_wr_en(mem_1_wr_en), .mem_1_wr_addr(mem_1_wr_addr), .mem_1_din(mem_1_din),
      .mem_2_wr_en(mem_2_wr_en), .mem_2_wr_addr(mem_2_wr_addr), .mem_2_din(mem_2_din),
      .mem_0_rd_en(mem_0_rd_en), .mem_0_rd_addr(mem_0_rd_addr),
      .mem_1_rd_en(mem_1_rd_en), .mem_1_rd_addr(mem_1_rd_addr),
      .mem_2_rd_en(mem_2_rd_en), .mem_2_rd_addr(mem_2_rd_addr),
      .mem_dout(mem_dout),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   // Three-region memory with a one-cycle read, counting writes per location to catch duplicates.
   always @(posedge clk) begin
      if (mem_0_wr_en) begin
         bus_mem[0][mem_0_wr_addr] <= mem_0_din;
         wr_cnt[0][mem_0_wr_addr]  <= wr_cnt[0][mem_0_wr_addr] + 1;
      end
      if (mem_1_wr_en) begin
         bus_mem[1][mem_1_wr_addr] <= mem_1_din;
         wr_cnt[1][mem_1_wr_addr]  <= wr_cnt[1][mem_1_wr_addr] + 1;
      end
      if (mem_2_wr_en) begin
         bus_mem[2][mem_2_wr_addr] <= mem_2_din;
         wr_cnt[2][mem_2_wr_addr]  <= wr_cnt[2][mem_2_wr_addr] + 1;
      end
      if (mem_0_rd_en)      mem_dout <= bus_mem[0][mem_0_rd_addr];
      else if (mem_1_rd_en) mem_dout <= bus_mem[1][mem_1_rd_addr];
      else if (mem_2_rd_en) mem_dout <= bus_mem[2][mem_2_rd_addr];
   end

   function automatic logic [2:0] sel3(input int n);
      case (n)
         0:       return 3'b001;
         1:       return 3'b010;
         2:       return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, "_busy"}, 64'(busy), 64'd0);
      checkOutput({name, "_done"}, 64'(done), 64'd0);
      checkOutput({name, "_s_ready"}, 64'(s_ready), 64'd0);
      checkOutput({name, "_m_valid"}, 64'(m_valid), 64'd0);
      checkOutput({name, "_m_data"}, 64'(m_data), 64'd0);
      checkOutput({name, "_enables"}, 64'({mem_0_wr_en, mem_1_wr_en, mem_2_wr_en, mem_0_rd_en, mem_1_rd_en, mem_2_rd_en}), 64'd0);
      checkOutput({name, "_addrs"}, 64'(mem_0_wr_addr | mem_1_wr_addr | mem_2_wr_addr | mem_0_rd_addr | mem_1_rd_addr | mem_2_rd_addr), 64'd0);
      checkOutput({name, "_din"}, 64'(mem_0_din | mem_1_din | mem_2_din), 64'd0);
      checkOutput({name, "_checksum"}, 64'(checksum), 64'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [WIDTH-1:0] words [TOTAL];
      logic [WIDTH-1:0] exp_sum, held;
      logic [2:0]       wr, rd;
      int base_cnt [3][16];
      int k, idx, rd_count, out_count, done_cycle, first_valid, busy_at_done, busy_seen;
      int write_err, read_err, data_err, hold_err, onehot_err, zero_err, outstanding_err, mem_err;
      bit hold_pending;
      idx = 0; rd_count = 0; out_count = 0; done_cycle = -1; first_valid = -1; busy_at_done = 0;
      write_err = 0; read_err = 0; data_err = 0; hold_err = 0; onehot_err = 0; zero_err = 0;
      outstanding_err = 0; mem_err = 0; busy_seen = 0; hold_pending = 0;
      exp_sum = '0; held = '0;
      for (int i = 0; i < TOTAL; i++) begin
         case (v.data_mode)
            0:       words[i] = WIDTH'(i);
            1:       words[i] = WIDTH'(1000 + i);
            default: words[i] = $urandom;
         endcase
      end
      for (int r = 0; r < 3; r++)
         for (int a = 0; a < 16; a++)
            base_cnt[r][a] = wr_cnt[r][a];

      @(negedge clk);
      start_load   = v.is_load;
      start_unload = !v.is_load || v.both_start;
      @(posedge clk); #1;
      start_load   = 1'b0;
      start_unload = 1'b0;
      k = 1;
      while (done_cycle < 0 && k <= 400) begin
         if (v.is_load) begin
            if (idx >= TOTAL)       s_valid = 1'b0;
            else if (v.pattern == 0) s_valid = 1'b1;
            else if (v.pattern == 1) s_valid = k[0];
            else                     s_valid = 1'($urandom_range(0, 1));
         end else begin
            s_valid = 1'($urandom_range(0, 1));
         end
         s_data = (v.is_load && s_valid && idx < TOTAL) ? words[idx] : WIDTH'($urandom);
         if (m_valid && first_valid < 0) first_valid = k;
         if (v.pattern == 2)      m_ready = !(first_valid >= 0 && k < first_valid + v.stall);
         else if (v.pattern == 3) m_ready = ($urandom_range(0, 3) != 0);
         else                     m_ready = 1'b1;
         start_unload = v.mid_start && (k == 10);
         @(negedge clk);
         wr = {mem_2_wr_en, mem_1_wr_en, mem_0_wr_en};
         rd = {mem_2_rd_en, mem_1_rd_en, mem_0_rd_en};
         if ($countones({wr, rd}) > 1) onehot_err++;
         if (done) begin
            done_cycle   = k;
            busy_at_done = int'(busy);
         end
         for (int p = 0; p < 3; p++) begin
            if (v.is_load) begin
               if (p != idx / DEPTH && (wr_en_a[p] || wr_addr_a[p] != 0 || din_a[p] != 0)) zero_err++;
               if (rd_en_a[p] || rd_addr_a[p] != 0) zero_err++;
            end else begin
               if (p != rd_count / DEPTH && (rd_en_a[p] || rd_addr_a[p] != 0)) zero_err++;
               if (wr_en_a[p] || wr_addr_a[p] != 0 || din_a[p] != 0) zero_err++;
            end
         end
         if (v.is_load) begin
            if (s_valid && s_ready && idx < TOTAL) begin
               if (wr != sel3(idx / DEPTH)) write_err++;
               else if (wr_addr_a[idx / DEPTH] != AW'(idx % DEPTH) || din_a[idx / DEPTH] != words[idx]) write_err++;
               ref_words[idx] = words[idx];
               exp_sum ^= words[idx];
               idx++;
            end else if (wr != 3'b000) begin
               write_err++;
            end
         end else begin
            if (s_ready) write_err++;
            if (rd != 3'b000) begin
               if (rd_count >= TOTAL) read_err++;
               else if (rd != sel3(rd_count / DEPTH)) read_err++;
               else if (rd_addr_a[rd_count / DEPTH] != AW'(rd_count % DEPTH)) read_err++;
               rd_count++;
            end
            if (hold_pending && (!m_valid || m_data != held)) hold_err++;
            hold_pending = 0;
            if (m_valid && m_ready) begin
               if (out_count < TOTAL) begin
                  if (m_data != ref_words[out_count]) data_err++;
                  exp_sum ^= ref_words[out_count];
               end else begin
                  data_err++;
               end
               out_count++;
            end else if (m_valid) begin
               hold_pending = 1;
               held         = m_data;
            end
            if (rd_count - out_count > 2) outstanding_err++;
         end
         @(posedge clk); #1;
         k++;
      end
      s_valid = 1'b0;
      m_ready = 1'b0;

      checkOutput("done_seen", 64'(done_cycle >= 0), 64'd1);
      if (v.exp_done >= 0) checkOutput("done_cycle", 64'(done_cycle), 64'(v.exp_done));
      checkOutput("busy_at_done", 64'(busy_at_done), 64'd0);
      checkOutput("single_enable", 64'(onehot_err), 64'd0);
      checkOutput("unselected_ports_zero", 64'(zero_err), 64'd0);
      checkOutput("write_order", 64'(write_err), 64'd0);
      if (v.is_load) begin
         checkOutput("load_handshakes", 64'(idx), 64'(TOTAL));
         for (int r = 0; r < 3; r++)
            for (int a = 0; a < 16; a++) begin
               if (a < DEPTH) begin
                  if (bus_mem[r][a] != ref_words[r * DEPTH + a] || wr_cnt[r][a] - base_cnt[r][a] != 1) mem_err++;
               end else if (wr_cnt[r][a] != base_cnt[r][a]) begin
                  mem_err++;
               end
            end
         checkOutput("mem_contents", 64'(mem_err), 64'd0);
      end else begin
         checkOutput("read_count", 64'(rd_count), 64'(TOTAL));
         checkOutput("read_order", 64'(read_err), 64'd0);
         checkOutput("out_count", 64'(out_count), 64'(TOTAL));
         checkOutput("out_data", 64'(data_err), 64'd0);
         checkOutput("hold_stable", 64'(hold_err), 64'd0);
         checkOutput("outstanding_le2", 64'(outstanding_err), 64'd0);
      end
      if (v.exp_first_valid >= 0) checkOutput("first_m_valid", 64'(first_valid), 64'(v.exp_first_valid));
`ifdef LOADER_CHECKSUM_EN
      checkOutput("checksum", 64'(checksum), 64'(exp_sum));
`else
      checkOutput("checksum", 64'(checksum), 64'd0);
`endif
      if (v.mid_start) begin
         repeat (3) begin
            @(negedge clk);
            busy_seen |= int'(busy);
         end
         checkOutput("start_during_load_ignored", 64'(busy_seen), 64'd0);
      end
   endtask

   task automatic resetMidUnload();
      int accepted;
      int guard;
      int done_seen;
      accepted = 0; guard = 0; done_seen = 0;
      @(negedge clk);
      start_unload = 1'b1;
      s_valid      = 1'b0;
      @(posedge clk); #1;
      start_unload = 1'b0;
      m_ready      = 1'b1;
      while (accepted < 20 && guard < 200) begin
         @(negedge clk);
         if (m_valid && m_ready) accepted++;
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("abort_reached_word20", 64'(accepted), 64'd20);
      checkOutput("abort_word20_data", 64'(m_data), 64'(ref_words[20]));
      rst_n = 1'b0;
      #1;
      checkResetState("abort");
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      m_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         done_seen |= int'(done);
      end
      checkOutput("no_done_after_abort", 64'(done_seen), 64'd0);
   endtask

   initial begin
      vec_t rv;
      rst_n = 1'b0; start_load = 1'b0; start_unload = 1'b0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      vectors[0] = '{1'b1, 0, 0,  0, 1'b0, 1'b0, 43, -1};
      vectors[1] = '{1'b0, 0, 0,  0, 1'b0, 1'b0, 45,  3};
      vectors[2] = '{1'b0, 2, 10, 0, 1'b0, 1'b0, 55,  3};
      vectors[3] = '{1'b1, 1, 0,  1, 1'b0, 1'b0, 84, -1};
      vectors[4] = '{1'b0, 0, 0,  0, 1'b0, 1'b0, 45,  3};
      vectors[5] = '{1'b1, 0, 0,  0, 1'b1, 1'b1, 43, -1};
      vectors[6] = '{1'b1, 3, 0,  2, 1'b0, 1'b0, -1, -1};
      vectors[7] = '{1'b0, 3, 0,  0, 1'b0, 1'b0, -1,  3};

      #12;
      checkResetState("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) applyStimulus(vectors[i]);

      resetMidUnload();
      rv = '{1'b1, 0, 0, 2, 1'b0, 1'b0, 43, -1};
      applyStimulus(rv);
      rv = '{1'b0, 0, 0, 0, 1'b0, 1'b0, 45, 3};
      applyStimulus(rv);

      for (int r = 0; r < 3; r++) begin
         rv = '{1'b1, 3, 0, 2, 1'b0, 1'b0, -1, -1};
         applyStimulus(rv);
         rv = '{1'b0, 3, 0, 0, 1'b0, 1'b0, -1, 3};
         applyStimulus(rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_stream_loader.md
# mem_stream_loader

Streaming initiator for the three-region shared single-port memory in the top controller. In LOAD, it accepts a valid/ready word stream and drives the three per-region write ports in order: region 0, then region 1, then region 2. In UNLOAD, it drives the three per-region read ports in the same order, absorbs the one-cycle memory read latency and presents the words as a valid/ready output stream. It connects directly to the region ports of the 3-to-1 memory wrapper and to the software-facing stream interface.

## Interface
- WIDTH, 32, data word width
- SINGLE_MEM_DEPTH, 14, words per region
- SINGLE_MEM_DEPTH_LOG, `CLOG2(SINGLE_MEM_DEPTH), region address width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start_load  in  1  one-cycle request to start a load
- start_unload  in  1  one-cycle request to start an unload
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse on completion
- s_valid, s_data  in  1, WIDTH  input stream
- s_ready  out  1  input stream ready
- m_valid, m_data  out  1, WIDTH  output stream
- m_ready  in  1  output stream ready
- mem_k_wr_en, mem_k_wr_addr, mem_k_din  out  1, SINGLE_MEM_DEPTH_LOG, WIDTH  write port of region k, k=0..2
- mem_k_rd_en, mem_k_rd_addr  out  1, SINGLE_MEM_DEPTH_LOG  read port of region k, k=0..2
- mem_dout  in  WIDTH  shared memory read data, valid the cycle after a read enable
- checksum  out  WIDTH  running XOR of transferred words (see Configuration)

## Operation
- States: IDLE, LOAD, UNLOAD, DRAIN.
- Registered counters:
  - region (0..2)
  - addr (0..SINGLE_MEM_DEPTH-1)
- Transfer length: 3*SINGLE_MEM_DEPTH words.
- IDLE:
  - start_load moves to LOAD.
  - start_unload moves to UNLOAD.
  - If both are asserted in the same cycle, load wins.
  - Both counters are cleared on entering either LOAD or UNLOAD.
  - Start requests are ignored in every non-IDLE state.
- LOAD:
  - s_ready = 1.
  - mem_{region}_wr_en = s_valid (combinational), with wr_addr = addr and din = s_data.
  - On each handshake, addr increments. When addr is SINGLE_MEM_DEPTH-1 it wraps to 0 and region increments.
  - The handshake on region 2 / last addr returns the block to IDLE and pulses done.
- UNLOAD:
  - A 2-entry output FIFO and a 1-bit in-flight flag are maintained.
  - Issue condition: mem_{region}_rd_en = 1 when fifo_count + inflight - (m_valid & m_ready) < 2. Otherwise rd_en = 0.
  - Each issued read advances the counters the same way as in LOAD.
  - mem_dout is pushed into the FIFO in the cycle after an issue.
  - After the last read is issued, the block moves to DRAIN.
- DRAIN: no new reads. When the FIFO is empty and inflight = 0, the block returns to IDLE and pulses done.
- m_valid = FIFO non-empty. m_data = FIFO head.
- At most one of the six enables is high in any cycle. Unselected ports drive 0 on enables, addresses and data.

## Timing
- Reset values:
  - State IDLE; counters, FIFO, inflight and checksum cleared.
  - busy, done, s_ready, m_valid and all mem enables are 0.
  - m_data, all addresses, din and checksum are 0.
- Load:
  - Throughput is 1 word/cycle. Write enable is in the same cycle as the stream handshake.
  - done pulses in the cycle after the final write; busy falls in that same cycle.
- Unload, with start_unload sampled at edge T:
  - First rd_en in cycle T+1.
  - First m_valid in cycle T+3.
  - Throughput is 1 word/cycle while m_ready = 1.
- m_valid/m_data hold stable until accepted. Backpressure never drops a word or issues an extra read.
- Asserting rst_n low mid-transfer aborts immediately: all state clears and pending FIFO data is discarded. No done pulse is produced.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - checksum XORs each loaded word on its s handshake and each unloaded word on its m handshake.
  - checksum clears at the start of each transfer and holds its value in IDLE.
- LOADER_CHECKSUM_EN undefined: checksum is tied to 0 and the XOR register is not built.

## Test plan
- Load with s_valid always high, data 0..41 (depth 14):
  - mem_0 writes addr 0..13 with data 0..13; mem_1 writes addr 0..13 with data 14..27; mem_2 writes addr 0..13 with data 28..41.
  - done pulses in the cycle after the write of word 41.
- Load with s_valid toggling every other cycle: exactly 42 writes, no duplicate addresses, done after 83 cycles in LOAD.
- Unload of a preloaded memory with m_ready = 1:
  - Output is 0..41 on consecutive cycles from T+3.
  - done in cycle T+45.
- Unload with m_ready = 0 for 10 cycles after the first m_valid:
  - At most 2 reads are outstanding.
  - Output sequence is 0..41 with no loss or duplication.
- start_load and start_unload asserted together: LOAD runs. A start_unload issued during LOAD is ignored.
- rst_n low during word 20 of an unload: all outputs return to their reset values at once. A following load starts at region 0, addr 0. With LOADER_CHECKSUM_EN defined, checksum reads 0 after the reset.
